// File: rtl/ac_regref_seq.sv
// ---------------------------------------------------------------------------
// ac_regref_seq
//
// Sequences one register-reference instruction on the AC/E datapath. The
// operand word is captured on start. The AC/E micro-operation strobes are
// then issued one per cycle in fixed priority order, and the skip tests are
// evaluated against the updated AC/E. The block reports done/skip and a
// sticky halt.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   start        request, sampled only in IDLE while halt=0
//   op[11:0]     register-reference word, captured with start
//                11 CLA 10 CLE 9 CMA 8 CME 7 CIR 6 CIL 5 INC
//                 4 SPA  3 SNA 2 SZA 1 SZE 0 HLT
//   ac_in        current AC from the AC/E block
//   e_in         current E from the AC/E block
//   ac_clr..ac_inc  AC/E strobes, at most one high per cycle
//   busy         high whenever not IDLE
//   done         one-cycle completion pulse
//   skip         skip result, valid only while done=1
//   halt         sticky halt flag, cleared only by reset
// ---------------------------------------------------------------------------
module ac_regref_seq #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [11:0]       op,
    input  logic [DATA_W-1:0] ac_in,
    input  logic              e_in,
    output logic              ac_clr,
    output logic              ac_cle,
    output logic              ac_cma,
    output logic              ac_cme,
    output logic              ac_cir,
    output logic              ac_cil,
    output logic              ac_inc,
    output logic              busy,
    output logic              done,
    output logic              skip,
    output logic              halt
);

    // state | meaning
    // IDLE  | waiting for start (ignored while halt=1)
    // EXEC  | one strobe per cycle for the highest pending micro-op bit
    // TEST  | AC/E settled; evaluate skip conditions
    // DONE  | done pulse, skip valid, halt raised if HLT was set
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        TEST = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [11:0] pend;

    // Micro-op field of the pending word, bit 6 = CLA ... bit 0 = INC.
    logic [6:0] mop_pend;
    logic [6:0] mop_sel;
    logic [6:0] mop_rest;
    logic       mop_found;

    logic       ac_sign;
    logic       ac_zero;
    logic       test_hit;

    assign mop_pend = pend[11:5];

    // Pick the highest-priority pending micro-op (CLA first, INC last).
    always_comb begin
        mop_sel   = '0;
        mop_found = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            if (mop_pend[i] && !mop_found) begin
                mop_sel[i] = 1'b1;
                mop_found  = 1'b1;
            end
        end
    end

    assign mop_rest = mop_pend & ~mop_sel;

    // Strobes decode straight from state and pending bits so the AC/E block
    // acts on the edge that ends the strobe cycle.
    always_comb begin
        {ac_clr, ac_cle, ac_cma, ac_cme, ac_cir, ac_cil, ac_inc} = 7'b0;
        if (state == EXEC) begin
            {ac_clr, ac_cle, ac_cma, ac_cme, ac_cir, ac_cil, ac_inc} = mop_sel;
        end
    end

    assign ac_sign  = ac_in[DATA_W-1];
    assign ac_zero  = (ac_in == '0);
    assign test_hit = (pend[4] & ~ac_sign)
                    | (pend[3] &  ac_sign)
                    | (pend[2] &  ac_zero)
                    | (pend[1] & ~e_in);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            skip  <= 1'b0;
            halt  <= 1'b0;
        end else begin
            done <= 1'b0;
            skip <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !halt) begin
                        pend  <= op;
                        busy  <= 1'b1;
                        state <= (|op[11:5]) ? EXEC : TEST;
                    end
                end
                EXEC: begin
                    pend[11:5] <= mop_rest;
                    if (mop_rest == '0) begin
                        state <= TEST;
                    end
                end
                TEST: begin
                    // skip and done land together so skip is only ever
                    // visible alongside done.
                    skip  <= test_hit;
                    done  <= 1'b1;
                    if (pend[0]) begin
                        halt <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    pend  <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_strobe_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({ac_clr, ac_cle, ac_cma, ac_cme, ac_cir, ac_cil, ac_inc}));

    a_skip_only_with_done : assert property (@(posedge clk) disable iff (!rst_n)
        skip |-> done);

    a_busy_matches_state : assert property (@(posedge clk) disable iff (!rst_n)
        busy == (state != IDLE));

    a_halt_sticky : assert property (@(posedge clk) disable iff (!rst_n)
        halt |=> halt);

endmodule

// File: tb/tb_ac_regref_seq.sv
module tb_ac_regref_seq;
    localparam int DATA_W = 16;
    localparam int NCYC   = 4096;

    typedef struct {
        int         cyc;
        logic [6:0] vec;
    } stb_exp_t;

    typedef struct {
        int   cyc;
        logic skip;
        logic halt;
    } done_exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [11:0]       op;
    logic [DATA_W-1:0] ac_in;
    logic              e_in;
    logic              ac_clr, ac_cle, ac_cma, ac_cme, ac_cir, ac_cil, ac_inc;
    logic              busy, done, skip, halt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    stb_exp_t  stb_q[$];
    done_exp_t done_q[$];

    logic [6:0] obs_stb  [NCYC];
    logic       obs_done [NCYC];
    logic       obs_skip [NCYC];
    logic       obs_halt [NCYC];
    logic       obs_busy [NCYC];

    // AC/E block model driven by the strobes
    logic [15:0] ac_mdl;
    logic        e_mdl;
    logic        ld_en;
    logic [15:0] ld_ac;
    logic        ld_e;

    ac_regref_seq #(.DATA_W(DATA_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .ac_in  (ac_in),
        .e_in   (e_in),
        .ac_clr (ac_clr),
        .ac_cle (ac_cle),
        .ac_cma (ac_cma),
        .ac_cme (ac_cme),
        .ac_cir (ac_cir),
        .ac_cil (ac_cil),
        .ac_inc (ac_inc),
        .busy   (busy),
        .done   (done),
        .skip   (skip),
        .halt   (halt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign ac_in = ac_mdl;
    assign e_in  = e_mdl;

    always @(posedge clk) begin
        if (ld_en) begin
            ac_mdl <= ld_ac;
            e_mdl  <= ld_e;
        end else begin
            if (ac_clr) ac_mdl <= '0;
            if (ac_cle) e_mdl <= 1'b0;
            if (ac_cma) ac_mdl <= ~ac_mdl;
            if (ac_cme) e_mdl <= ~e_mdl;
            if (ac_cir) begin
                ac_mdl <= {e_mdl, ac_mdl[15:1]};
                e_mdl  <= ac_mdl[0];
            end
            if (ac_cil) begin
                ac_mdl <= {ac_mdl[14:0], e_mdl};
                e_mdl  <= ac_mdl[15];
            end
            if (ac_inc) ac_mdl <= ac_mdl + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (cyc < NCYC) begin
            obs_stb[cyc]  <= {ac_clr, ac_cle, ac_cma, ac_cme, ac_cir, ac_cil, ac_inc};
            obs_done[cyc] <= done;
            obs_skip[cyc] <= skip;
            obs_halt[cyc] <= halt;
            obs_busy[cyc] <= busy;
        end
    end

    function automatic logic predict(input logic [11:0] o, input logic [15:0] a0,
                                     input logic e0, output logic [15:0] a,
                                     output logic e);
        logic c;
        a = a0;
        e = e0;
        if (o[11]) a = '0;
        if (o[10]) e = 1'b0;
        if (o[9])  a = ~a;
        if (o[8])  e = ~e;
        if (o[7]) begin c = a[0];  a = {e, a[15:1]}; e = c; end
        if (o[6]) begin c = a[15]; a = {a[14:0], e}; e = c; end
        if (o[5])  a = a + 16'd1;
        return (o[4] & ~a[15]) | (o[3] & a[15]) | (o[2] & (a == 16'd0)) | (o[1] & ~e);
    endfunction

    task automatic set_ace(input logic [15:0] a, input logic e);
        ld_ac = a;
        ld_e  = e;
        ld_en = 1'b1;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Starts one op at the current cycle, scores strobes/done/skip/halt/busy,
    // and returns at the first cycle a new start may be accepted.
    task automatic run_op(input logic [11:0] op_v, input logic exp_skip,
                          input logic exp_halt, input int repulse, input string name);
        int         s;
        int         k;
        int         dcyc;
        logic       got;
        logic [6:0] extra;
        stb_exp_t   se;
        done_exp_t  de;
        s = cyc;
        k = 0;
        for (int b = 11; b >= 5; b--) begin
            if (op_v[b]) begin
                k++;
                se.cyc = s + k;
                se.vec = '0;
                se.vec[b-5] = 1'b1;
                stb_q.push_back(se);
            end
        end
        de.cyc  = s + k + 2;
        de.skip = exp_skip;
        de.halt = exp_halt;
        done_q.push_back(de);

        start = 1'b1;
        op    = op_v;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 12'hFFF;
        got   = 1'b0;
        dcyc  = -1;
        for (int n = 1; n <= 12; n++) begin
            start = (n == repulse);
            @(negedge clk);
            if (done === 1'b1) begin
                got  = 1'b1;
                dcyc = cyc;
            end
            @(posedge clk); #1;
            if (got) break;
        end
        start = 1'b0;

        de = done_q.pop_front();
        checks++;
        if (!got || dcyc != de.cyc) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, dcyc - s, de.cyc - s);
        end else begin
            checks++;
            if (obs_skip[dcyc] !== de.skip) begin
                errors++;
                $display("FAIL %s skip: got %b expected %b", name, obs_skip[dcyc], de.skip);
            end
            checks++;
            if (obs_halt[dcyc] !== de.halt) begin
                errors++;
                $display("FAIL %s halt: got %b expected %b", name, obs_halt[dcyc], de.halt);
            end
        end
        while (stb_q.size() > 0) begin
            se = stb_q.pop_front();
            checks++;
            if (obs_stb[se.cyc] !== se.vec) begin
                errors++;
                $display("FAIL %s strobe cycle %0d: got %b expected %b",
                         name, se.cyc - s, obs_stb[se.cyc], se.vec);
            end
        end
        extra = obs_stb[s] | obs_stb[s+k+1] | obs_stb[s+k+2];
        checks++;
        if (extra !== 7'b0) begin
            errors++;
            $display("FAIL %s strobe_outside_exec: got %b expected 0000000", name, extra);
        end
        checks++;
        if ({obs_busy[s], obs_busy[s+1], obs_busy[s+k+2]} !== 3'b011) begin
            errors++;
            $display("FAIL %s busy(c0,c1,ck+2): got %b expected 011", name,
                     {obs_busy[s], obs_busy[s+1], obs_busy[s+k+2]});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        op    = 12'h000;
        ld_en = 1'b0;
        ld_ac = 16'h0000;
        ld_e  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, skip, halt, ac_clr, ac_cle, ac_cma, ac_cme, ac_cir, ac_cil, ac_inc} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {busy, done, skip, halt, ac_clr, ac_cle, ac_cma, ac_cme, ac_cir, ac_cil, ac_inc});
        end
        rst_n = 1'b1;
        set_ace(16'h1234, 1'b0);
    endtask

    task automatic test_reset_mid();
        int         s;
        logic [6:0] stb_or;
        logic       done_or;
        s = cyc;
        start = 1'b1;
        op    = 12'hFE0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, skip, halt, ac_clr, ac_cle, ac_cma, ac_cme, ac_cir, ac_cil, ac_inc} !== 11'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected all zero",
                     {busy, done, skip, halt, ac_clr, ac_cle, ac_cma, ac_cme, ac_cir, ac_cil, ac_inc});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (obs_stb[s+1] !== 7'b1000000 || obs_stb[s+2] !== 7'b0100000) begin
            errors++;
            $display("FAIL midreset_pre_strobes: got %b %b expected 1000000 0100000",
                     obs_stb[s+1], obs_stb[s+2]);
        end
        stb_or  = '0;
        done_or = 1'b0;
        for (int c = s + 3; c < s + 14; c++) begin
            stb_or  = stb_or | obs_stb[c];
            done_or = done_or | obs_done[c] | obs_busy[c];
        end
        checks++;
        if (stb_or !== 7'b0 || done_or !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: strobes %b done/busy %b expected 0", stb_or, done_or);
        end
        run_op(12'hFE0, 1'b0, 1'b0, 0, "post_reset_fe0");
    endtask

    task automatic test_cla_cma();
        set_ace(16'h1234, 1'b0);
        run_op(12'hA00, 1'b0, 1'b0, 0, "cla_cma");
        checks++;
        if (ac_mdl !== 16'hFFFF) begin
            errors++;
            $display("FAIL cla_cma_ac: got %h expected ffff", ac_mdl);
        end
    endtask

    task automatic test_skip_tests();
        set_ace(16'h5A5A, 1'b0);
        run_op(12'h804, 1'b1, 1'b0, 0, "cla_sza");
        set_ace(16'h8000, 1'b0);
        run_op(12'h008, 1'b1, 1'b0, 0, "sna_neg");
        set_ace(16'h7FFF, 1'b0);
        run_op(12'h008, 1'b0, 1'b0, 0, "sna_pos");
        set_ace(16'h7FFF, 1'b1);
        run_op(12'h010, 1'b1, 1'b0, 0, "spa_pos");
        run_op(12'h002, 1'b0, 1'b0, 0, "sze_e1");
        run_op(12'h000, 1'b0, 1'b0, 0, "nop");
    endtask

    task automatic test_all_mops();
        set_ace(16'h1234, 1'b0);
        run_op(12'hFE0, 1'b0, 1'b0, 3, "all_mops");
        checks++;
        if (ac_mdl !== 16'h0000 || e_mdl !== 1'b1) begin
            errors++;
            $display("FAIL all_mops_ace: got %h/%b expected 0000/1", ac_mdl, e_mdl);
        end
        set_ace(16'h8001, 1'b1);
        run_op(12'h080, 1'b0, 1'b0, 0, "cir");
        checks++;
        if (ac_mdl !== 16'hC000 || e_mdl !== 1'b1) begin
            errors++;
            $display("FAIL cir_ace: got %h/%b expected c000/1", ac_mdl, e_mdl);
        end
    endtask

    task automatic test_back_to_back();
        set_ace(16'h5A5A, 1'b1);
        run_op(12'h804, 1'b1, 1'b0, 0, "b2b_cla_sza");
        run_op(12'h004, 1'b1, 1'b0, 0, "b2b_sza");
        run_op(12'h024, 1'b0, 1'b0, 0, "b2b_inc_sza");
        run_op(12'h00A, 1'b0, 1'b0, 0, "b2b_sna_sze");
        run_op(12'h402, 1'b1, 1'b0, 0, "b2b_cle_sze");
    endtask

    task automatic test_random();
        logic [11:0] o;
        logic [15:0] a0;
        logic        e0;
        logic [15:0] pa;
        logic        pe;
        logic        ps;
        for (int i = 0; i < 8; i++) begin
            o  = 12'($urandom_range(0, 4095)) & 12'hFFE;
            a0 = 16'($urandom_range(0, 65535));
            e0 = 1'($urandom_range(0, 1));
            ps = predict(o, a0, e0, pa, pe);
            set_ace(a0, e0);
            run_op(o, ps, 1'b0, 0, "random");
            checks++;
            if (ac_mdl !== pa || e_mdl !== pe) begin
                errors++;
                $display("FAIL random_ace op %h: got %h/%b expected %h/%b", o, ac_mdl, e_mdl, pa, pe);
            end
        end
    endtask

    task automatic test_halt();
        logic bad;
        set_ace(16'h0001, 1'b0);
        run_op(12'h001, 1'b0, 1'b1, 0, "hlt");
        checks++;
        if (obs_halt[cyc-2] !== 1'b0) begin
            errors++;
            $display("FAIL hlt_rise_early: got %b expected 0", obs_halt[cyc-2]);
        end
        bad = 1'b0;
        for (int n = 0; n < 6; n++) begin
            start = 1'b1;
            op    = 12'h800;
            @(negedge clk);
            if (busy !== 1'b0 || halt !== 1'b1 || done !== 1'b0 ||
                {ac_clr, ac_cle, ac_cma, ac_cme, ac_cir, ac_cil, ac_inc} !== 7'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL hlt_ignore_start: got activity %b expected 0", bad);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (halt !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hlt_reset_clear: got halt %b busy %b expected 0 0", halt, busy);
        end
        rst_n = 1'b1;
        run_op(12'h804, 1'b1, 1'b0, 0, "after_halt");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid();
        test_cla_cma();
        test_skip_tests();
        test_all_mops();
        test_back_to_back();
        test_random();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ac_regref_seq.md
# ac_regref_seq

Sequencer for register-reference instructions on the accumulator/extension (AC/E) datapath. It accepts a 12-bit register-reference operand word (IR[11:0]) through a start/done handshake and issues the AC/E micro-operation strobes one per cycle, in a fixed order. It then evaluates the skip conditions against the updated AC/E and reports skip and halt to the main control unit. It sits between the instruction decoder and the AC/E register block.

## Interface
- DATA_W, 16, accumulator width (AC sign bit is bit DATA_W-1).

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  12  register-reference word; sampled with start. Bit map: 11 CLA, 10 CLE, 9 CMA, 8 CME, 7 CIR, 6 CIL, 5 INC, 4 SPA, 3 SNA, 2 SZA, 1 SZE, 0 HLT.
- ac_in  in  DATA_W  current AC value from the AC/E block.
- e_in  in  1  current E bit from the AC/E block.
- ac_clr, ac_cle, ac_cma, ac_cme, ac_cir, ac_cil, ac_inc  out  1 each  AC/E strobes; at most one high per cycle.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at completion.
- skip  out  1  skip result, valid only while done=1, else 0.
- halt  out  1  sticky halt flag.

## Operation
- The FSM has four states: IDLE, EXEC, TEST, DONE.
- **IDLE:**
  - start=1 with halt=0: capture op into a pending register.
  - Go to EXEC if any of op[11:5] is set, else go to TEST.
  - start is ignored when halt=1 or in any other state. It is never queued.
- **EXEC:**
  - Each cycle, assert the strobe for the highest-priority pending bit and clear that bit.
  - Priority order: CLA > CLE > CMA > CME > CIR > CIL > INC.
  - Unset bits consume no cycles.
  - After the cycle that issues the last set bit, go to TEST.
- **Strobes:**
  - Decoded combinationally from the state and the pending register.
  - Low outside EXEC.
  - Each strobe takes effect in the AC/E block on the rising edge that ends its cycle.
- **TEST:** sample ac_in and e_in, which already reflect every strobe issued. Register skip as the OR of the selected conditions:
  - SPA: ac_in[DATA_W-1]=0.
  - SNA: ac_in[DATA_W-1]=1.
  - SZA: ac_in=0.
  - SZE: e_in=0.
  - With no test bits set, skip=0.
- **DONE:**
  - done=1 and skip is valid.
  - If captured op[0]=1, set halt in this same cycle.
  - Go to IDLE next cycle.
- op=0x000 is legal: there are no strobes, and the block still passes through TEST and DONE with skip=0.
- halt stays 1 until reset.

## Timing
- Reset values: all strobes, busy, done, skip and halt are 0; state is IDLE; the pending register is 0.
- Reset mid-operation: rst_n=0 sampled at an edge forces IDLE. After that edge there are no further strobes and the pending operation is discarded with no done pulse.
- Cycle numbering: start is sampled at the edge ending cycle 0, and k is the number of set bits in op[11:5].
- Cycles 1..k: EXEC, one strobe per cycle.
- Cycle k+1: TEST.
- Cycle k+2: DONE (done=1).
- Cycle k+3: IDLE. A new start is accepted in cycle k+3.
- busy is high in cycles 1..k+2.
- Bounds:
  - Minimum latency is start to done = 2 cycles (k=0).
  - Maximum is 9 cycles (k=7).
  - Throughput is one op per k+3 cycles.
- ac_in/e_in are only sampled in TEST. Changes at any other time have no effect.

## Test plan
1. Reset: hold rst_n=0 for 2 cycles during an EXEC of op=0xFE0 -> all outputs 0 after the edge, no strobe afterward, no done; the next start is accepted normally.
2. op=0xA00 (CLA+CMA), AC model starts at 0x1234 -> ac_clr in cycle 1, ac_cma in cycle 2, done in cycle 4, AC=0xFFFF, skip=0.
3. op=0x804 (CLA+SZA), AC=0x5A5A -> ac_clr in cycle 1; TEST sees 0x0000; done in cycle 3 with skip=1.
4. op=0x008 (SNA), no strobes -> with ac_in=0x8000, done in cycle 2 with skip=1; repeat with ac_in=0x7FFF -> skip=0.
5. op=0xFE0:
   - Strobes are one-hot in cycles 1..7, in order clr, cle, cma, cme, cir, cil, inc.
   - done in cycle 9.
   - start re-pulsed in cycle 3 is ignored.
   - Also check E=1, AC=0x8001 with op=0x080 (CIR) -> AC=0xC000, E=1.
6. op=0x001 (HLT) -> done and halt rise in cycle 2; halt stays high; later starts are ignored (busy stays 0) until rst_n=0.
